// File: rtl/rr_issue_arbiter_if.sv
// Handshake bundle between the issue-queue ready vector, the round-robin
// arbiter and the functional-unit port.
interface rr_issue_arbiter_if #(
    parameter int N = 4
);
    localparam int IDXW = $clog2(N);

    logic [N-1:0]    req;
    logic            flush;
    logic            fu_ready;
    logic            grant_valid;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] grant_idx;
    logic            issue_fire;
    logic            busy;

    // Issue-queue / FU side: supplies requests, flush and FU readiness.
    modport master (
        output req, flush, fu_ready,
        input  grant_valid, grant, grant_idx, issue_fire, busy
    );

    // Arbiter side.
    modport slave (
        input  req, flush, fu_ready,
        output grant_valid, grant, grant_idx, issue_fire, busy
    );
endinterface

// File: rtl/rr_issue_arbiter.sv
// Round-robin arbiter sharing one functional unit among N requesters.
// A grant is registered one cycle after arbitration and held until the FU
// accepts it; priority then rotates past the winner. A multi-cycle FU is
// modelled by a BUSY countdown so that fires are exactly LATENCY apart.
module rr_issue_arbiter #(
    parameter  int N       = 4,
    parameter  int LATENCY = 1,
    localparam int IDXW    = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_issue_arbiter_if.slave bus
);
    localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [IDXW-1:0] ptr_reg, ptr_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic            gv_reg, gv_next;
    logic [IDXW-1:0] idx_reg, idx_next;
    logic [N-1:0]    grant_reg, grant_next;

    logic            fire;
    logic [IDXW:0]   arb_res;     // {found, index}
    logic [IDXW-1:0] ptr_fire;    // pointer just past the current winner

    // First set bit of v scanning p, p+1, ..., N-1, 0, ..., p-1.
    // Walking offsets from high to low lets the closest offset win last.
    function automatic logic [IDXW:0] arb(input logic [N-1:0] v, input logic [IDXW-1:0] p);
        logic [IDXW:0] res;
        int            pos;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(p) + k;
            if (pos >= N) pos = pos - N;
            if (v[pos]) res = {1'b1, IDXW'(pos)};
        end
        return res;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [N-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // A flush always suppresses the handshake, even when the FU is ready.
    assign fire     = gv_reg & bus.fu_ready & ~bus.flush;
    assign ptr_fire = (idx_reg == IDXW'(N - 1)) ? '0 : idx_reg + 1'b1;

    // Next-state and next-grant selection.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        gv_next    = 1'b0;
        idx_next   = '0;
        grant_next = '0;
        arb_res    = '0;
        unique case (state_reg)
            IDLE: begin
                if (bus.flush) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (|bus.req) begin
                    arb_res    = arb(bus.req, ptr_reg);
                    state_next = GRANT;
                    gv_next    = 1'b1;
                    idx_next   = arb_res[IDXW-1:0];
                    grant_next = onehot(arb_res[IDXW-1:0]);
                end
            end
            GRANT: begin
                if (bus.flush) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (fire) begin
                    ptr_next = ptr_fire;
                    if (LATENCY == 1) begin
                        // Back-to-back issue: the winner just served is excluded.
                        arb_res = arb(bus.req & ~grant_reg, ptr_fire);
                        if (arb_res[IDXW]) begin
                            state_next = GRANT;
                            gv_next    = 1'b1;
                            idx_next   = arb_res[IDXW-1:0];
                            grant_next = onehot(arb_res[IDXW-1:0]);
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next   = CNTW'(LATENCY - 1);
                        state_next = BUSY;
                    end
                end else if (!bus.req[idx_reg]) begin
                    // Requester withdrew before being served; priority is kept.
                    state_next = IDLE;
                end else begin
                    gv_next    = 1'b1;
                    idx_next   = idx_reg;
                    grant_next = grant_reg;
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNTW'(1)) begin
                    // Last busy cycle: arbitrate so the next grant lands exactly
                    // LATENCY cycles after the previous fire.
                    cnt_next = '0;
                    arb_res  = arb(bus.req, ptr_reg);
                    if (arb_res[IDXW]) begin
                        state_next = GRANT;
                        gv_next    = 1'b1;
                        idx_next   = arb_res[IDXW-1:0];
                        grant_next = onehot(arb_res[IDXW-1:0]);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            gv_reg    <= 1'b0;
            idx_reg   <= '0;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            gv_reg    <= gv_next;
            idx_reg   <= idx_next;
            grant_reg <= grant_next;
        end
    end

    assign bus.grant_valid = gv_reg;
    assign bus.grant       = grant_reg;
    assign bus.grant_idx   = idx_reg;
    assign bus.issue_fire  = fire;
    assign bus.busy        = (state_reg == BUSY);
endmodule

// File: tb/tb_rr_issue_arbiter.sv
// Bench for rr_issue_arbiter: three instances (LATENCY 1, 3, 4) share one
// stimulus stream and are each compared every cycle against a countdown
// reference model, with directed checks for the documented scenarios.
module tb_rr_issue_arbiter;
    localparam int N  = 4;
    localparam int ND = 3;

    logic clk;
    logic rst_n;
    logic [N-1:0] req;
    logic flush;
    logic fu_ready;

    logic [ND-1:0]        gv_o, fire_o, busy_o;
    logic [ND-1:0][N-1:0] gnt_o;
    logic [ND-1:0][1:0]   gidx_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: offered index (-1 none), busy cycles left, pointer.
    int lat    [ND] = '{1, 3, 4};
    int m_off  [ND];
    int m_cool [ND];
    int m_ptr  [ND];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        rr_issue_arbiter_if #(.N(N)) bus ();
        assign bus.req      = req;
        assign bus.flush    = flush;
        assign bus.fu_ready = fu_ready;
        rr_issue_arbiter #(
            .N       (N),
            .LATENCY ((gi == 0) ? 1 : (gi == 1) ? 3 : 4)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign gv_o[gi]   = bus.grant_valid;
        assign gnt_o[gi]  = bus.grant;
        assign gidx_o[gi] = bus.grant_idx;
        assign fire_o[gi] = bus.issue_fire;
        assign busy_o[gi] = bus.busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rotating scan starting at p; -1 when nothing is requesting.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            m_off[k]  = -1;
            m_cool[k] = 0;
            m_ptr[k]  = 0;
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < ND; k++) begin
            logic         e_gv;
            logic [N-1:0] e_gnt;
            logic [1:0]   e_idx;
            e_gv  = (m_off[k] >= 0);
            e_gnt = e_gv ? (N'(1) << m_off[k]) : '0;
            e_idx = e_gv ? 2'(m_off[k]) : 2'd0;
            chk($sformatf("grant_valid[%0d]", k), 32'(gv_o[k]), 32'(e_gv));
            chk($sformatf("grant[%0d]", k), 32'(gnt_o[k]), 32'(e_gnt));
            chk($sformatf("grant_idx[%0d]", k), 32'(gidx_o[k]), 32'(e_idx));
            chk($sformatf("issue_fire[%0d]", k), 32'(fire_o[k]), 32'(e_gv & fu_ready & ~flush));
            chk($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(m_cool[k] > 0));
        end
    endtask

    task automatic step_model();
        for (int k = 0; k < ND; k++) begin
            int off;
            bit fired;
            off   = m_off[k];
            fired = (off >= 0) && fu_ready && !flush;
            if (!rst_n) begin
                m_off[k] = -1; m_cool[k] = 0; m_ptr[k] = 0;
            end else if (flush) begin
                m_off[k] = -1; m_cool[k] = 0;
            end else if (fired) begin
                m_ptr[k] = (off + 1) % N;
                if (lat[k] == 1) begin
                    m_off[k] = pick(req & ~(N'(1) << off), m_ptr[k]);
                end else begin
                    m_off[k]  = -1;
                    m_cool[k] = lat[k] - 1;
                end
            end else if (off >= 0) begin
                if (!req[off]) m_off[k] = -1;
            end else if (m_cool[k] > 0) begin
                m_cool[k]--;
                if (m_cool[k] == 0) m_off[k] = pick(req, m_ptr[k]);
            end else begin
                m_off[k] = pick(req, m_ptr[k]);
            end
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        step_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; flush = 1'b0; fu_ready = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_grant_valid", 32'(gv_o), 32'd0);
        chk("reset_grant", 32'(gnt_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        tick();

        // 1: no requests -> nothing offered, nothing fired
        rst_n = 1'b1; req = 4'b0000; fu_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #1;
            chk("t1_grant_valid", 32'(gv_o), 32'd0);
            chk("t1_issue_fire", 32'(fire_o), 32'd0);
            tick();
        end
        $display("test 1 idle: done");

        // 2: req=0110 from reset, L=1 alternates 1,2 every cycle
        req = 4'b0110; fu_ready = 1'b1;
        do_reset();
        rst_n = 1'b1;
        for (int j = 0; j < 9; j++) begin
            #1;
            if (j == 0) chk("t2_first_gv", 32'(gv_o[0]), 32'd0);
            else begin
                chk("t2_idx", 32'(gidx_o[0]), (j % 2 == 1) ? 32'd1 : 32'd2);
                chk("t2_fire", 32'(fire_o[0]), 32'd1);
            end
            tick();
        end
        $display("test 2 back-to-back: done");

        // 3: held grant on 3 while FU stalls, then fire wraps pointer to 0
        req = 4'b1000; fu_ready = 1'b0;
        do_reset();
        rst_n = 1'b1;
        tick();
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("t3_hold_grant", 32'(gnt_o[0]), 32'h8);
            chk("t3_hold_idx", 32'(gidx_o[0]), 32'd3);
            chk("t3_no_fire", 32'(fire_o[0]), 32'd0);
            tick();
        end
        fu_ready = 1'b1;
        #1;
        chk("t3_fire", 32'(fire_o[0]), 32'd1);
        tick();
        req = 4'b1001;
        #1;
        chk("t3_idle_after_fire", 32'(gv_o[0]), 32'd0);
        tick();
        #1;
        chk("t3_wrap_gv", 32'(gv_o[0]), 32'd1);
        chk("t3_wrap_idx", 32'(gidx_o[0]), 32'd0);
        tick();
        $display("test 3 stall and wrap: done");

        // 4: L=3 with all requesting: fires at t, t+3, t+6 on 0,1,2
        req = 4'b1111; fu_ready = 1'b1;
        do_reset();
        rst_n = 1'b1;
        for (int j = 0; j < 9; j++) begin
            #1;
            chk("t4_fire", 32'(fire_o[1]), (j == 1 || j == 4 || j == 7) ? 32'd1 : 32'd0);
            chk("t4_busy", 32'(busy_o[1]), (j == 2 || j == 3 || j == 5 || j == 6 || j == 8) ? 32'd1 : 32'd0);
            if (j == 1 || j == 4 || j == 7) chk("t4_idx", 32'(gidx_o[1]), 32'((j - 1) / 3));
            tick();
        end
        $display("test 4 initiation interval: done");

        // 5: flush overrides a ready FU; pointer survives the flush
        req = 4'b0100; fu_ready = 1'b0;
        do_reset();
        rst_n = 1'b1;
        tick();
        flush = 1'b1; fu_ready = 1'b1;
        #1;
        chk("t5_idx_before", 32'(gidx_o[0]), 32'd2);
        chk("t5_flush_no_fire", 32'(fire_o[0]), 32'd0);
        tick();
        flush = 1'b0; fu_ready = 1'b0;
        #1;
        chk("t5_gv_cleared", 32'(gv_o[0]), 32'd0);
        chk("t5_busy_cleared", 32'(busy_o), 32'd0);
        tick();
        #1;
        chk("t5_regrant_idx", 32'(gidx_o[0]), 32'd2);
        chk("t5_regrant_gv", 32'(gv_o[0]), 32'd1);
        tick();
        $display("test 5 flush: done");

        // 6: asynchronous reset in the middle of a BUSY period (L=4)
        req = 4'b0001; fu_ready = 1'b1;
        do_reset();
        rst_n = 1'b1;
        tick();
        tick();
        #1;
        chk("t6_busy_before", 32'(busy_o[2]), 32'd1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_gv", 32'(gv_o[2]), 32'd0);
        chk("t6_async_grant", 32'(gnt_o[2]), 32'd0);
        chk("t6_async_busy", 32'(busy_o[2]), 32'd0);
        tick();
        req = 4'b0010; rst_n = 1'b1;
        #1;
        chk("t6_release_fire", 32'(fire_o), 32'd0);
        chk("t6_release_gv", 32'(gv_o), 32'd0);
        tick();
        #1;
        chk("t6_first_idx", 32'(gidx_o[2]), 32'd1);
        chk("t6_first_gv", 32'(gv_o[2]), 32'd1);
        tick();
        $display("test 6 async reset: done");

        // Random traffic against the model, with occasional flush and reset
        for (int j = 0; j < 1500; j++) begin
            req      = 4'($urandom_range(0, 15));
            flush    = ($urandom_range(0, 19) == 0);
            fu_ready = ($urandom_range(0, 9) < 7);
            rst_n    = ($urandom_range(0, 299) != 0);
            if (!rst_n) model_reset();
            tick();
        end
        $display("random phase: 1500 cycles done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
